// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART program loader:
//   - RAM_DEPTH / ADDR_W  : size of the programmed RAM (16 x 8)
//   - rx_state_t          : receiver FSM state encoding
//   - calc_clks_per_bit() : clock-to-baud ratio rounded to nearest integer
// ----------------------------------------------------------------------------
package loader_pkg;

    localparam int RAM_DEPTH = 32'sd16;
    localparam int ADDR_W    = 32'sd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Round-to-nearest division of the clock rate by the baud rate
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + (baud / 32'sd2)) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 byte receiver: 2-flop synchronizer, baud counter and receive FSM.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : asynchronous serial line, idle high
//   enable      : receiver active when high; low aborts any frame
//   data[7:0]   : last received byte (stable while valid/frame_err pulse)
//   valid       : one-clock strobe during the clock a good stop bit is sampled
//   frame_err   : one-clock strobe during the clock a bad stop bit is sampled
//   busy        : registered, high from START entry through the stop sample
// ----------------------------------------------------------------------------
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32'sd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 32'sd1) ? $clog2(CLKS_PER_BIT) : 32'sd1;
    localparam int HALF  = (CLKS_PER_BIT >= 32'sd2) ? (CLKS_PER_BIT / 32'sd2) : 32'sd1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'sd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             rx_s;
    rx_state_t        state_r;
    rx_state_t        next_state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             busy_r;
    logic             tick_s;
    logic             cnt_clr_s;
    logic             bit_clr_s;
    logic             shift_en_s;
    logic             valid_s;
    logic             ferr_s;

    assign rx_s = sync2_r;

    // Two-flop synchronizer on the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Sample point: half a bit into the start bit, then once per full bit
    always_comb begin
        if (state_r == ST_START) begin
            tick_s = (baud_cnt_r == HALF_LAST);
        end else begin
            tick_s = (baud_cnt_r == BIT_LAST);
        end
    end

    // Receive FSM next-state and per-clock strobes
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        bit_clr_s    = 1'b0;
        shift_en_s   = 1'b0;
        valid_s      = 1'b0;
        ferr_s       = 1'b0;
        if (!enable) begin
            next_state_s = ST_IDLE;
            cnt_clr_s    = 1'b1;
            bit_clr_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_clr_s = 1'b1;
                    bit_clr_s = 1'b1;
                    if (!rx_s) begin
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        cnt_clr_s = 1'b1;
                        // A high line at mid-start-bit is a glitch, not an error
                        if (!rx_s) begin
                            next_state_s = ST_DATA;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end else begin
                        next_state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_clr_s  = 1'b1;
                        shift_en_s = 1'b1;
                        if (bit_cnt_r == 3'd7) begin
                            next_state_s = ST_STOP;
                        end else begin
                            next_state_s = ST_DATA;
                        end
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_clr_s = 1'b1;
                        if (rx_s) begin
                            valid_s      = 1'b1;
                            next_state_s = ST_IDLE;
                        end else begin
                            ferr_s       = 1'b1;
                            next_state_s = ST_WAIT_IDLE;
                        end
                    end else begin
                        next_state_s = ST_STOP;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt_clr_s = 1'b1;
                    // Wait out the broken frame so its low level is not a new start
                    if (rx_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_WAIT_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    cnt_clr_s    = 1'b1;
                    bit_clr_s    = 1'b1;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Baud/bit counters, LSB-first shift register and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            if (cnt_clr_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_ONE;
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {rx_s, shift_r[7:1]};
            end
            busy_r <= (next_state_s == ST_START) || (next_state_s == ST_DATA) ||
                      (next_state_s == ST_STOP);
        end
    end

    assign data      = shift_r;
    assign valid     = valid_s;
    assign frame_err = ferr_s;
    assign busy      = busy_r;

endmodule

// File: rtl/uart_program_loader.sv
// ----------------------------------------------------------------------------
// uart_program_loader
// Receives bytes over UART and writes them into consecutive locations of a
// 16 x 8 RAM. Optional feature macro: LOADER_CHECKSUM_EN -- a 17th byte is a
// checksum (sum of the 16 data bytes mod 256) that gates done.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   rx              : asynchronous UART line, 8N1, idle high
//   enable          : loader active when high; rising edge restarts a load
//   prog_addr[3:0]  : RAM address of the current write
//   prog_data[7:0]  : byte to write (holds between writes)
//   prog_we         : single-cycle RAM write strobe
//   busy            : a frame is being received
//   done            : all 16 locations written (checksum-verified if enabled)
//   frame_err       : sticky framing/checksum error
// ----------------------------------------------------------------------------
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 32'sd27000000,
    parameter int BAUD   = 32'sd115200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              enable,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic              prog_we,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 32'sd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'sd1);

    logic [7:0]        rx_data_s;
    logic              rx_valid_s;
    logic              rx_ferr_s;
    logic              rx_busy_s;
    logic              enable_d_r;
    logic              enable_rise_s;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] prog_addr_r;
    logic [7:0]        prog_data_r;
    logic              prog_we_r;
    logic              done_r;
    logic              frame_err_r;
    logic              write_s;
    logic              done_nxt_s;
    logic              ferr_nxt_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_r;
    logic [7:0]        sum_nxt_s;
    logic              chk_pend_r;
    logic              chk_pend_nxt_s;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .enable    (enable),
        .data      (rx_data_s),
        .valid     (rx_valid_s),
        .frame_err (rx_ferr_s),
        .busy      (rx_busy_s)
    );

    assign enable_rise_s = enable & ~enable_d_r;

    // Decide what an incoming byte does to the write strobe, done and error flags
    always_comb begin
        write_s    = 1'b0;
        done_nxt_s = done_r;
        ferr_nxt_s = frame_err_r;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt_s      = sum_r;
        chk_pend_nxt_s = chk_pend_r;
`endif
        if (enable_rise_s) begin
            done_nxt_s = 1'b0;
            ferr_nxt_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_nxt_s      = 8'h00;
            chk_pend_nxt_s = 1'b0;
`endif
        end else if (enable && rx_valid_s) begin
`ifdef LOADER_CHECKSUM_EN
            if (chk_pend_r) begin
                // Checksum byte: never written, only judges the block
                chk_pend_nxt_s = 1'b0;
                if (rx_data_s == sum_r) begin
                    done_nxt_s = 1'b1;
                end else begin
                    ferr_nxt_s = 1'b1;
                end
            end else begin
                write_s        = 1'b1;
                done_nxt_s     = 1'b0;
                // Address 0 starts a new block, so the running sum restarts there
                sum_nxt_s      = ((wr_cnt_r == {ADDR_W{1'b0}}) ? 8'h00 : sum_r) + rx_data_s;
                chk_pend_nxt_s = (wr_cnt_r == LAST_ADDR);
            end
`else
            write_s    = 1'b1;
            done_nxt_s = (wr_cnt_r == LAST_ADDR);
`endif
        end else if (enable && rx_ferr_s) begin
            ferr_nxt_s = 1'b1;
        end else begin
            write_s = 1'b0;
        end
    end

    // Write port registers, write counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_d_r  <= 1'b0;
            wr_cnt_r    <= '0;
            prog_addr_r <= '0;
            prog_data_r <= 8'h00;
            prog_we_r   <= 1'b0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            enable_d_r  <= enable;
            prog_we_r   <= write_s;
            done_r      <= done_nxt_s;
            frame_err_r <= ferr_nxt_s;
            if (write_s) begin
                prog_addr_r <= wr_cnt_r;
                prog_data_r <= rx_data_s;
            end
            // Counter advances the clock after the strobe, wrapping 15 -> 0
            if (enable_rise_s) begin
                wr_cnt_r <= '0;
            end else if (prog_we_r) begin
                wr_cnt_r <= wr_cnt_r + ADDR_ONE;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running checksum and "next byte is the checksum" flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= 8'h00;
            chk_pend_r <= 1'b0;
        end else begin
            sum_r      <= sum_nxt_s;
            chk_pend_r <= chk_pend_nxt_s;
        end
    end
`endif

    assign prog_addr = prog_addr_r;
    assign prog_data = prog_data_r;
    assign prog_we   = prog_we_r;
    assign busy      = rx_busy_s;
    assign done      = done_r;
    assign frame_err = frame_err_r;

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD rounded to nearest integer.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous UART line, 8N1, idle high.
REQ-006 SHALL have port enable  input  1  loader active when high (RAM programming mode switch).
REQ-007 SHALL have port prog_addr  output  4  RAM address of the current write.
REQ-008 SHALL have port prog_data  output  8  byte to write.
REQ-009 SHALL have port prog_we  output  1  single-cycle RAM write strobe.
REQ-010 SHALL have port busy  output  1  high while a frame is being received.
REQ-011 SHALL have port done  output  1  high once all 16 locations are written.
REQ-012 SHALL have port frame_err  output  1  sticky: a frame had stop bit = 0.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-014 Receiver FSM SHALL use states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE->START on synchronized rx = 0 while enable = 1; bit counter cleared.
REQ-016 START SHALL re-sample rx after CLKS_PER_BIT/2 clocks; low -> DATA, high -> IDLE (glitch, no error).
REQ-017 DATA SHALL sample 8 bits LSB first, one every CLKS_PER_BIT clocks, then -> STOP.
REQ-018 STOP SHALL sample after CLKS_PER_BIT clocks; 1 -> byte accepted, -> IDLE; 0 -> byte discarded, frame_err = 1, -> WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE when synchronized rx = 1.
REQ-020 On acceptance, prog_we SHALL be 1 for exactly the clock after the stop-bit sample, with prog_data = byte and prog_addr = write counter.
REQ-021 Write counter (4 bits) SHALL increment the clock after prog_we, wrapping 15 -> 0.
REQ-022 done SHALL set on the write to address 15 and clear on the next accepted byte.
REQ-023 busy SHALL be 1 from START entry through the stop-bit sample, 0 otherwise.
REQ-024 enable low SHALL abort any frame (no write), force FSM to IDLE, hold prog_we = 0; prog_addr, done, frame_err hold.
REQ-025 enable rising edge SHALL clear write counter, done, frame_err.
REQ-026 prog_data SHALL hold its last value when prog_we = 0.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, counters 0, prog_addr 0, prog_data 0, prog_we 0, busy 0, done 0, frame_err 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the frame; no prog_we after release until a full new frame.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, a 17th accepted byte SHALL be a checksum: done sets only if (sum of the 16 bytes) mod 256 equals it; otherwise frame_err sets; the checksum byte never asserts prog_we.
REQ-030 Without LOADER_CHECKSUM_EN, REQ-022 applies unchanged and no checksum logic is synthesized.

Structure
REQ-031 Package loader_pkg SHALL hold the receiver state enum, RAM_DEPTH = 16 and ADDR_W = 4.
REQ-032 Byte reception (synchronizer, baud counter, FSM) SHALL be sub-module uart_rx with outputs data[7:0], valid, frame_err, busy; uart_program_loader holds counter, done and checksum.

Verification (CLK_HZ = 1000000, BAUD = 100000, 10 clk/bit)
REQ-033 Send 0x1E after reset -> one prog_we pulse, prog_addr 0, prog_data 0x1E, counter then 1, frame_err 0.
REQ-034 Send 16 bytes 0x00..0x0F -> 16 pulses at addresses 0..15 with matching data; done = 1 after 16th; 17th byte 0xAA -> address 0, done 0 (checksum off).
REQ-035 Frame 0x55 with stop bit 0 -> no prog_we, frame_err = 1, counter unchanged; next valid byte written.
REQ-036 rx low for 3 clocks only -> no busy past START, no write, no error.
REQ-037 Drop enable mid-DATA of 0x77 -> no write; raise enable -> counter 0, done 0, frame_err 0.
REQ-038 LOADER_CHECKSUM_EN: 16 bytes 0x01 plus checksum 0x10 -> done = 1; checksum 0x11 -> done = 0, frame_err = 1.
